riscv_muldiv: RTL

RISCV_MULDIV -- requirements
Module: riscv_muldiv

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/riscv_muldiv_if.sv | 26 ++
 rtl/riscv_muldiv.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M constants, funct3 encodings and decode helpers
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int MULDIV_LATENCY = 34;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input muldiv_op_t op);
    logic [2:0] f;
    f = op;
    return f[2];
  endfunction

  // Upper accumulator half holds MULH* products and REM* remainders
  function automatic logic op_sel_hi(input muldiv_op_t op);
    logic [2:0] f;
    f = op;
    return f[2] ? f[1] : (f[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// rtl/riscv_muldiv_if.sv - request/write-back bundle between core and mul/div unit
interface riscv_muldiv_if;
  import riscv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [4:0]       rd_in;
  logic             kill;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  logic [4:0]       rd_out;

  modport master (
    output start, op, a, b, rd_in, kill,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, a, b, rd_in, kill,
    output busy, done, result, rd_out
  );

endinterface

// File: rtl/riscv_muldiv.sv
// rtl/riscv_muldiv.sv - iterative radix-2 RV32M multiply/divide unit, 34-cycle latency
module riscv_muldiv
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  riscv_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state_q;
  muldiv_op_t           op_q;
  logic [4:0]           cnt_q;
  logic [2*XLEN-1:0]    acc_q;
  logic [XLEN-1:0]      b_q;
  logic                 neg_a_q;
  logic                 neg_b_q;
  logic [4:0]           rd_lat_q;
  logic                 busy_q;
  logic                 done_q;
  logic [XLEN-1:0]      result_q;
  logic [4:0]           rd_out_q;

  logic                 a_neg_d;
  logic                 b_neg_d;
  logic [XLEN-1:0]      a_mag_d;
  logic [XLEN-1:0]      b_mag_d;
  logic [XLEN:0]        mul_sum;
  logic [XLEN:0]        div_shift;
  logic                 div_ge;
  logic [XLEN-1:0]      div_rem;
  logic [2*XLEN-1:0]    step_d;
  logic [2*XLEN-1:0]    fix_d;
  logic [XLEN-1:0]      sel_d;

  // Operand sign handling and magnitude extraction for the incoming request
  always_comb begin
    a_neg_d = 1'b0;
    b_neg_d = 1'b0;
    if ((bus.op == OP_MULH) || (bus.op == OP_MULHSU) || (bus.op == OP_DIV) || (bus.op == OP_REM))
      a_neg_d = bus.a[XLEN-1];
    if ((bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM))
      b_neg_d = bus.b[XLEN-1];
    a_mag_d = a_neg_d ? -bus.a : bus.a;
    b_mag_d = b_neg_d ? -bus.b : bus.b;
  end

  // One radix-2 step: shift-add multiply or restoring divide, sharing acc_q
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
    if (op_is_div(op_q))
      step_d = {div_rem, acc_q[XLEN-2:0], div_ge};
    else
      step_d = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Sign correction; a zero divisor keeps the all-ones quotient unsigned-looking
  always_comb begin
    fix_d = acc_q;
    if (op_is_div(op_q)) begin
      if (neg_a_q)
        fix_d[2*XLEN-1:XLEN] = -acc_q[2*XLEN-1:XLEN];
      if ((neg_a_q ^ neg_b_q) && (b_q != '0))
        fix_d[XLEN-1:0] = -acc_q[XLEN-1:0];
    end else if (neg_a_q ^ neg_b_q) begin
      fix_d = -acc_q;
    end
    sel_d = op_sel_hi(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  end

  // Control FSM with registered busy/done/result/rd_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= 5'd0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rd_lat_q <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start && !bus.kill) begin
            op_q     <= bus.op;
            acc_q    <= {{XLEN{1'b0}}, a_mag_d};
            b_q      <= b_mag_d;
            neg_a_q  <= a_neg_d;
            neg_b_q  <= b_neg_d;
            rd_lat_q <= bus.rd_in;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_CALC: begin
          if (bus.kill) begin
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= step_d;
            if (cnt_q == 5'd31) begin
              cnt_q   <= 5'd0;
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        S_FIX: begin
          if (bus.kill) begin
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == 5'd0) begin
            acc_q <= fix_d;
            cnt_q <= 5'd1;
          end else begin
            result_q <= sel_d;
            rd_out_q <= rd_lat_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= 5'd0;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
